// File: rtl/icache_pkg.sv
// Shared types and width helpers for the set-associative instruction cache.
// Contents:
//   state_e  - line-fill controller states
//   cnt_w()  - counter width for n states, never less than 1 bit
package icache_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FILL    = 2'd1,
        S_INSTALL = 2'd2
    } state_e;

    // Width of a counter that must hold values 0..n-1 (at least one bit)
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/icache_way.sv
// One way of the instruction cache: valid/tag/data storage, tag compare and
// word select for the lookup port, and a whole-line write port for install.
// Ports:
//   i_clk, i_rst    clock, asynchronous active-high reset (valid bits only)
//   i_clr_all       invalidate every set of this way at the next edge
//   i_rd_idx/tag/off lookup address fields
//   o_match         set valid and tag equal (combinational)
//   o_word          selected word of the indexed line (combinational)
//   o_set_valid     valid bit of the indexed set, for victim choice
//   i_wr_en/idx/tag/line  install a full line and mark it valid
module icache_way
    import icache_pkg::*;
#(
    parameter int unsigned WORD_W     = 16,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned SETS       = 8,
    parameter int unsigned IDX_W      = 3,
    parameter int unsigned OFF_W      = 2,
    parameter int unsigned TAG_W      = 11
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_clr_all,
    input  logic [IDX_W-1:0]             i_rd_idx,
    input  logic [TAG_W-1:0]             i_rd_tag,
    input  logic [OFF_W-1:0]             i_rd_off,
    output logic                         o_match,
    output logic [WORD_W-1:0]            o_word,
    output logic                         o_set_valid,
    input  logic                         i_wr_en,
    input  logic [IDX_W-1:0]             i_wr_idx,
    input  logic [TAG_W-1:0]             i_wr_tag,
    input  logic [LINE_WORDS*WORD_W-1:0] i_wr_line
);

    logic [SETS-1:0]                    r_valid;
    logic [TAG_W-1:0]                   r_tag  [SETS];
    logic [LINE_WORDS-1:0][WORD_W-1:0]  r_data [SETS];

    // Clear-all then install: an install on the same edge as a flush stays valid
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= '0;
        end else begin
            if (i_clr_all) r_valid <= '0;
            if (i_wr_en)   r_valid[i_wr_idx] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_tag[i_wr_idx]  <= i_wr_tag;
            r_data[i_wr_idx] <= i_wr_line;
        end
    end

    assign o_set_valid = r_valid[i_rd_idx];
    assign o_match     = r_valid[i_rd_idx] && (r_tag[i_rd_idx] == i_rd_tag);
    assign o_word      = r_data[i_rd_idx][i_rd_off];

endmodule

// File: rtl/icache_sa_ctrl.sv
// Set-associative instruction cache (1 or 2 ways) with a line-fill controller.
// Hits return the word in the lookup cycle; a miss stalls fetch, reads the line
// in BUS_WORDS-wide beats, installs it into the victim way and replays lookup.
// Optional build macro ICACHE_PERF_EN adds saturating hit/miss counters.
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_cpu_re, i_cpu_addr  fetch request and word address
//   i_flush               invalidate all lines
//   o_cpu_instr           fetched word (0 when not a hit)
//   o_cpu_stall           fetch must hold its address
//   o_mem_re, o_mem_addr  registered beat request and BUS_WORDS-aligned address
//   i_mem_rdy, i_mem_rd_data  beat accepted / beat data, lowest word lowest
//   o_hit_cnt, o_miss_cnt (ICACHE_PERF_EN only) performance counters
module icache_sa_ctrl
    import icache_pkg::*;
#(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned WORD_W     = 16,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned SETS       = 8,
    parameter int unsigned WAYS       = 2,
    parameter int unsigned BUS_WORDS  = 2
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_cpu_re,
    input  logic [ADDR_W-1:0]             i_cpu_addr,
    input  logic                          i_flush,
    output logic [WORD_W-1:0]             o_cpu_instr,
    output logic                          o_cpu_stall,
    output logic                          o_mem_re,
    output logic [ADDR_W-1:0]             o_mem_addr,
`ifdef ICACHE_PERF_EN
    output logic [31:0]                   o_hit_cnt,
    output logic [31:0]                   o_miss_cnt,
`endif
    input  logic                          i_mem_rdy,
    input  logic [BUS_WORDS*WORD_W-1:0]   i_mem_rd_data
);

    localparam int unsigned IDX_W  = $clog2(SETS);
    localparam int unsigned OFF_W  = $clog2(LINE_WORDS);
    localparam int unsigned TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int unsigned BEATS  = LINE_WORDS / BUS_WORDS;
    localparam int unsigned BEAT_W = cnt_w(BEATS);

    // Lookup address fields
    logic [TAG_W-1:0] w_tag;
    logic [IDX_W-1:0] w_idx;
    logic [OFF_W-1:0] w_off;
    assign w_tag = i_cpu_addr[ADDR_W-1 -: TAG_W];
    assign w_idx = i_cpu_addr[OFF_W +: IDX_W];
    assign w_off = i_cpu_addr[OFF_W-1:0];

    state_e                               r_state;
    logic [TAG_W-1:0]                     r_tag_l;
    logic [IDX_W-1:0]                     r_idx_l;
    logic                                 r_victim;
    logic [BEAT_W-1:0]                    r_beat_cnt;
    logic                                 r_mem_re;
    logic [ADDR_W-1:0]                    r_mem_addr;
    logic [BEATS-1:0][BUS_WORDS*WORD_W-1:0] r_fill_buf;

    logic [WAYS-1:0]   w_match;
    logic [WAYS-1:0]   w_set_valid;
    logic [WORD_W-1:0] w_word [WAYS];
    logic              w_hit_any;
    logic              w_hit_way;
    logic [WORD_W-1:0] w_hit_word;
    logic              w_hit;
    logic              w_victim;

    // Way array: lookup on the live fetch address, install from the fill buffer
    for (genvar g = 0; g < WAYS; g++) begin : g_way
        icache_way #(
            .WORD_W     (WORD_W),
            .LINE_WORDS (LINE_WORDS),
            .SETS       (SETS),
            .IDX_W      (IDX_W),
            .OFF_W      (OFF_W),
            .TAG_W      (TAG_W)
        ) u_way (
            .i_clk       (i_clk),
            .i_rst       (i_rst),
            .i_clr_all   (i_flush),
            .i_rd_idx    (w_idx),
            .i_rd_tag    (w_tag),
            .i_rd_off    (w_off),
            .o_match     (w_match[g]),
            .o_word      (w_word[g]),
            .o_set_valid (w_set_valid[g]),
            .i_wr_en     ((r_state == S_INSTALL) && (r_victim == 1'(g))),
            .i_wr_idx    (r_idx_l),
            .i_wr_tag    (r_tag_l),
            .i_wr_line   (r_fill_buf)
        );
    end

    // Hit/way mux
    always_comb begin
        w_hit_any  = |w_match;
        w_hit_way  = 1'b0;
        w_hit_word = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (w_match[i]) begin
                w_hit_way  = 1'(i);
                w_hit_word = w_word[i];
            end
        end
    end

    // A flush cycle never counts as a hit
    assign w_hit       = i_cpu_re & w_hit_any & ~i_flush;
    assign o_cpu_instr = w_hit ? w_hit_word : '0;
    assign o_cpu_stall = (i_cpu_re & ~w_hit) | (r_state != S_IDLE);

    // Victim choice and LRU (LRU bit names the way to replace next)
    if (WAYS == 1) begin : g_dm
        assign w_victim = 1'b0;
    end else begin : g_2w
        logic [SETS-1:0] r_lru;

        assign w_victim = ~w_set_valid[0] ? 1'b0 :
                          ~w_set_valid[1] ? 1'b1 : r_lru[w_idx];

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                r_lru <= '0;
            end else if ((r_state == S_IDLE) && w_hit) begin
                r_lru[w_idx] <= ~w_hit_way;
            end else if (r_state == S_INSTALL) begin
                r_lru[r_idx_l] <= ~r_victim;
            end
        end
    end

    // Next-state and next-output logic
    state_e            w_state_nxt;
    logic [BEAT_W-1:0] w_beat_nxt;
    logic              w_start;
    logic              w_beat_take;
    logic [ADDR_W-1:0] w_base_nxt;
    logic              w_mem_re_nxt;
    logic [ADDR_W-1:0] w_mem_addr_nxt;

    always_comb begin
        w_state_nxt    = r_state;
        w_beat_nxt     = r_beat_cnt;
        w_start        = 1'b0;
        w_beat_take    = 1'b0;
        w_base_nxt     = '0;
        w_mem_re_nxt   = 1'b0;
        w_mem_addr_nxt = '0;

        case (r_state)
            S_IDLE: begin
                if (i_cpu_re && !w_hit && !i_flush) begin
                    w_state_nxt = S_FILL;
                    w_beat_nxt  = '0;
                    w_start     = 1'b1;
                end
            end
            S_FILL: begin
                if (i_mem_rdy) begin
                    w_beat_take = 1'b1;
                    if (r_beat_cnt == BEAT_W'(BEATS - 1)) begin
                        w_state_nxt = S_INSTALL;
                        w_beat_nxt  = '0;
                    end else begin
                        w_beat_nxt = r_beat_cnt + 1'b1;
                    end
                end
            end
            S_INSTALL: w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase

        w_base_nxt = w_start ? {w_tag, w_idx, OFF_W'(0)} : {r_tag_l, r_idx_l, OFF_W'(0)};
        w_mem_re_nxt = (w_state_nxt == S_FILL);
        if (w_mem_re_nxt) begin
            w_mem_addr_nxt = w_base_nxt + ADDR_W'(w_beat_nxt) * ADDR_W'(BUS_WORDS);
        end
    end

    // State register; reset drops the request and discards any partial line
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_beat_cnt <= '0;
            r_tag_l    <= '0;
            r_idx_l    <= '0;
            r_victim   <= 1'b0;
            r_mem_re   <= 1'b0;
            r_mem_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_beat_cnt <= w_beat_nxt;
            r_mem_re   <= w_mem_re_nxt;
            r_mem_addr <= w_mem_addr_nxt;
            if (w_start) begin
                r_tag_l  <= w_tag;
                r_idx_l  <= w_idx;
                r_victim <= w_victim;
            end
        end
    end

    // Fill buffer is data-only storage
    always_ff @(posedge i_clk) begin
        if (w_beat_take) r_fill_buf[r_beat_cnt] <= i_mem_rd_data;
    end

    assign o_mem_re   = r_mem_re;
    assign o_mem_addr = r_mem_addr;

`ifdef ICACHE_PERF_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    // Saturating counters; flush leaves them alone
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if ((r_state == S_IDLE) && w_hit && (r_hit_cnt != '1)) r_hit_cnt <= r_hit_cnt + 32'd1;
            if (w_start && (r_miss_cnt != '1)) r_miss_cnt <= r_miss_cnt + 32'd1;
        end
    end

    assign o_hit_cnt  = r_hit_cnt;
    assign o_miss_cnt = r_miss_cnt;
`endif

endmodule

// File: tb/tb_icache_sa_ctrl.sv
// Self-checking bench for icache_sa_ctrl: directed fetch vectors with a
// fixed-latency memory responder, plus sequences for flush, reset mid-fill and
// (with ICACHE_PERF_EN) the performance counters.
module tb_icache_sa_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_cpu_re = 1'b0;
    logic [15:0] i_cpu_addr = '0;
    logic        i_flush = 1'b0;
    logic [15:0] o_cpu_instr;
    logic        o_cpu_stall;
    logic        o_mem_re;
    logic [15:0] o_mem_addr;
    logic        i_mem_rdy = 1'b0;
    logic [31:0] i_mem_rd_data = '0;
`ifdef ICACHE_PERF_EN
    logic [31:0] o_hit_cnt;
    logic [31:0] o_miss_cnt;
`endif

    always #5 clk = ~clk;

    icache_sa_ctrl dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_cpu_re      (i_cpu_re),
        .i_cpu_addr    (i_cpu_addr),
        .i_flush       (i_flush),
        .o_cpu_instr   (o_cpu_instr),
        .o_cpu_stall   (o_cpu_stall),
        .o_mem_re      (o_mem_re),
        .o_mem_addr    (o_mem_addr),
`ifdef ICACHE_PERF_EN
        .o_hit_cnt     (o_hit_cnt),
        .o_miss_cnt    (o_miss_cnt),
`endif
        .i_mem_rdy     (i_mem_rdy),
        .i_mem_rd_data (i_mem_rd_data)
    );

    int          errors = 0;
    int          checks = 0;
    int          beats  = 0;
    bit          rdy_spam = 1'b0;
    logic [15:0] beat_addr [$];

    // Memory image: upper byte is the inverted lower address byte
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {~a[7:0], a[7:0]};
    endfunction

    // Responder: beat ready on the 4th cycle of each request
    initial begin
        int w;
        w = 0;
        forever begin
            @(negedge clk);
            if (o_mem_re && !rst) begin
                w++;
                if (w == 4) begin
                    i_mem_rdy     = 1'b1;
                    i_mem_rd_data = {mem_word(o_mem_addr + 16'd1), mem_word(o_mem_addr)};
                    beats++;
                    beat_addr.push_back(o_mem_addr);
                    w = 0;
                end else begin
                    i_mem_rdy = 1'b0;
                end
            end else begin
                w = 0;
                i_mem_rdy = rdy_spam;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Hold a fetch until the stall drops; caller starts just after a negedge
    task automatic do_fetch(input logic [15:0] a, output int n, output logic [15:0] instr);
        i_cpu_re   = 1'b1;
        i_cpu_addr = a;
        i_flush    = 1'b0;
        n = 0;
        instr = '0;
        for (int k = 0; k < 200; k++) begin
            #1;
            if (!o_cpu_stall) begin
                instr = o_cpu_instr;
                break;
            end
            n++;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        i_cpu_re = 1'b0;
    endtask

    task automatic check_fetch(input string nm, input logic [15:0] a, input int exp_n,
                               input logic [15:0] exp_instr, input int exp_beats);
        int          n;
        int          b0;
        logic [15:0] instr;
        b0 = beats;
        do_fetch(a, n, instr);
        chk({nm, "_stall_cycles"}, 32'(n), 32'(exp_n));
        chk({nm, "_instr"}, 32'(instr), 32'(exp_instr));
        chk({nm, "_beats"}, 32'(beats - b0), 32'(exp_beats));
    endtask

    typedef struct {
        logic [15:0] addr;
        int          stall;
        logic [15:0] instr;
        int          nbeats;
    } vec_t;

    vec_t tbl [13];

    initial begin
        int          low_cyc;
        int          b0;
        bit          found;
        logic [15:0] instr;

        // Two-way LRU walk over set 2 (tags 0, 2, 4) plus set 1
        tbl = '{
            '{16'h0008, 10, 16'hF708, 2},
            '{16'h0048, 10, 16'hB748, 2},
            '{16'h0009,  0, 16'hF609, 0},
            '{16'h004B,  0, 16'hB44B, 0},
            '{16'h0008,  0, 16'hF708, 0},
            '{16'h0088, 10, 16'h7788, 2},
            '{16'h0008,  0, 16'hF708, 0},
            '{16'h004A, 10, 16'hB54A, 2},
            '{16'h008B, 10, 16'h748B, 2},
            '{16'h0049,  0, 16'hB649, 0},
            '{16'h000B, 10, 16'hF40B, 2},
            '{16'h0007,  0, 16'hF807, 0},
            '{16'h0084, 10, 16'h7B84, 2}
        };

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        chk("rst_stall",  32'(o_cpu_stall), 32'd0);
        chk("rst_mem_re", 32'(o_mem_re),    32'd0);
        chk("rst_mem_addr", 32'(o_mem_addr), 32'd0);
        chk("rst_instr",  32'(o_cpu_instr), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Cold miss at 0x0004, cycle 1 is the first request cycle
        @(negedge clk);
        beat_addr.delete();
        i_cpu_re   = 1'b1;
        i_cpu_addr = 16'h0004;
        low_cyc    = 0;
        instr      = '0;
        for (int c = 1; c <= 60; c++) begin
            #1;
            if (c == 1) chk("t1_c1_mem_re", 32'(o_mem_re), 32'd0);
            if (c == 2) begin
                chk("t1_c2_mem_re", 32'(o_mem_re), 32'd1);
                chk("t1_c2_mem_addr", 32'(o_mem_addr), 32'h0004);
            end
            if (c == 6)  chk("t1_c6_mem_addr", 32'(o_mem_addr), 32'h0006);
            if (c == 10) chk("t1_install_mem_re", 32'(o_mem_re), 32'd0);
            if (!o_cpu_stall) begin
                low_cyc = c;
                instr   = o_cpu_instr;
                break;
            end
            @(negedge clk);
        end
        chk("t1_stall_low_cycle", 32'(low_cyc), 32'd11);
        chk("t1_instr", 32'(instr), 32'hFB04);
        chk("t1_beat_count", 32'(beat_addr.size()), 32'd2);
        chk("t1_beat0_addr", 32'(beat_addr[0]), 32'h0004);
        chk("t1_beat1_addr", 32'(beat_addr[1]), 32'h0006);
        @(posedge clk);
        #1;
        i_cpu_re = 1'b0;

        // Table of fetches
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            check_fetch($sformatf("v%0d", i), tbl[i].addr, tbl[i].stall, tbl[i].instr, tbl[i].nbeats);
        end

        // mem_rdy outside a fill is ignored
        rdy_spam = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_fetch("spam_hit", 16'h0005, 0, 16'hFA05, 0);
        @(negedge clk);
        check_fetch("spam_miss", 16'h00C0, 10, 16'h3FC0, 2);
        rdy_spam = 1'b0;

        // Flush pulsed during the fill of 0x0010
        @(negedge clk);
        b0 = beats;
        i_cpu_re   = 1'b1;
        i_cpu_addr = 16'h0010;
        low_cyc = 0;
        instr   = '0;
        for (int c = 1; c <= 60; c++) begin
            i_flush = (c == 4);
            #1;
            if (!o_cpu_stall) begin
                low_cyc = c;
                instr   = o_cpu_instr;
                break;
            end
            @(negedge clk);
        end
        i_flush = 1'b0;
        chk("t4_stall_low_cycle", 32'(low_cyc), 32'd11);
        chk("t4_instr", 32'(instr), 32'hEF10);
        chk("t4_beats", 32'(beats - b0), 32'd2);
        @(posedge clk);
        #1;
        i_cpu_re = 1'b0;
        @(negedge clk);
        check_fetch("t4_old_line", 16'h0007, 10, 16'hF807, 2);
        @(negedge clk);
        check_fetch("t4_new_line", 16'h0010, 0, 16'hEF10, 0);

        // Flush in IDLE with a hitting address: stall, no fill, then a real miss
        @(negedge clk);
        i_cpu_re   = 1'b1;
        i_cpu_addr = 16'h0010;
        i_flush    = 1'b1;
        #1;
        chk("flush_idle_stall", 32'(o_cpu_stall), 32'd1);
        chk("flush_idle_instr", 32'(o_cpu_instr), 32'd0);
        @(negedge clk);
        i_flush = 1'b0;
        #1;
        chk("flush_idle_no_fill", 32'(o_mem_re), 32'd0);
        check_fetch("flush_idle_refetch", 16'h0010, 10, 16'hEF10, 2);

        // Reset after the first beat of a fill
        @(negedge clk);
        b0 = beats;
        i_cpu_re   = 1'b1;
        i_cpu_addr = 16'h0020;
        found = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            #1;
            if (beats != b0) begin
                found = 1'b1;
                break;
            end
        end
        chk("t5_first_beat_seen", 32'(found), 32'd1);
        @(posedge clk);
        #1;
        chk("t5_second_beat_addr", 32'(o_mem_addr), 32'h0022);
        rst = 1'b1;
        #1;
        chk("t5_rst_mem_re", 32'(o_mem_re), 32'd0);
        chk("t5_rst_mem_addr", 32'(o_mem_addr), 32'd0);
        chk("t5_rst_stall", 32'(o_cpu_stall), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        beat_addr.delete();
        check_fetch("t5_refetch", 16'h0020, 10, 16'hDF20, 2);
        chk("t5_restart_beat0", 32'(beat_addr[0]), 32'h0020);
        chk("t5_restart_beat1", 32'(beat_addr[1]), 32'h0022);
        @(negedge clk);
        check_fetch("t5_valid_cleared", 16'h0010, 10, 16'hEF10, 2);

`ifdef ICACHE_PERF_EN
        // Counters: two misses (each replays as a hit) and one plain hit
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("perf_rst_hit", o_hit_cnt, 32'd0);
        chk("perf_rst_miss", o_miss_cnt, 32'd0);
        @(negedge clk);
        check_fetch("perf_m0", 16'h0004, 10, 16'hFB04, 2);
        @(negedge clk);
        check_fetch("perf_h0", 16'h0005, 0, 16'hFA05, 0);
        @(negedge clk);
        check_fetch("perf_m1", 16'h0008, 10, 16'hF708, 2);
        #1;
        chk("perf_hit_cnt", o_hit_cnt, 32'd3);
        chk("perf_miss_cnt", o_miss_cnt, 32'd2);
        @(negedge clk);
        force dut.r_hit_cnt  = 32'hFFFF_FFFE;
        force dut.r_miss_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_hit_cnt;
        release dut.r_miss_cnt;
        @(negedge clk);
        check_fetch("perf_sat_h0", 16'h0005, 0, 16'hFA05, 0);
        @(negedge clk);
        check_fetch("perf_sat_h1", 16'h0006, 0, 16'hF906, 0);
        @(negedge clk);
        check_fetch("perf_sat_m0", 16'h0100, 10, 16'hFF00, 2);
        #1;
        chk("perf_hit_sat", o_hit_cnt, 32'hFFFF_FFFF);
        chk("perf_miss_sat", o_miss_cnt, 32'hFFFF_FFFF);
`endif

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
